sqrt_pipe: RTL

Parametrised, fully pipelined integer square-root unit: one root bit resolved per stage, MSB first, with a trial-square register carried alongside the partial root. Generalises the fixed 16-bit square-root stage registers to IN_WIDTH operands with a valid/ready handshake, backpressure, a pass-through tag and a remainder output. Sits between the operand source and the result consumer; accepts one operand per cycle when not stalled.

---
 rtl/sqrt_pipe.sv | 107 ++++++++++
 1 files changed

// File: rtl/sqrt_pipe.sv
// Fully pipelined integer square root. One root bit is resolved per stage, MSB
// first; each stage carries the partial root and its square so the trial
// comparison needs only shifts and adds. Valid/ready handshake with global
// stall: every stage advances together or holds together.
module sqrt_pipe #(
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned TAG_WIDTH  = 4,
  localparam int unsigned ROOT_WIDTH = IN_WIDTH / 2,
  localparam int unsigned SQ_WIDTH   = IN_WIDTH + 1,
  localparam int unsigned REM_WIDTH  = ROOT_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [IN_WIDTH-1:0]   input_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ROOT_WIDTH-1:0] root_o,
  output logic [REM_WIDTH-1:0]  rem_o,
  output logic [TAG_WIDTH-1:0]  tag_o
);

  // Odd or tiny operand widths have no meaningful root split.
  if ((IN_WIDTH % 2) != 0 || IN_WIDTH < 4) begin : g_bad_width
    $error("sqrt_pipe: IN_WIDTH must be even and >= 4");
  end

  logic en;

  for (genvar s = 0; s < ROOT_WIDTH; s++) begin : g_stage
    // Root bit resolved by this stage.
    localparam int unsigned B = ROOT_WIDTH - 1 - s;

    logic                  valid_prev;
    logic [IN_WIDTH-1:0]   in_prev;
    logic [TAG_WIDTH-1:0]  tag_prev;
    logic [ROOT_WIDTH-1:0] root_prev;
    logic [SQ_WIDTH-1:0]   sq_prev;

    logic [SQ_WIDTH-1:0]   cand_sq;
    logic [ROOT_WIDTH-1:0] root_d;
    logic [SQ_WIDTH-1:0]   sq_d;

    logic                  valid_q;
    logic [IN_WIDTH-1:0]   in_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [ROOT_WIDTH-1:0] root_q;
    logic [SQ_WIDTH-1:0]   sq_q;

    if (s == 0) begin : g_first
      assign valid_prev = in_valid_i;
      assign in_prev    = input_i;
      assign tag_prev   = tag_i;
      assign root_prev  = '0;
      assign sq_prev    = '0;
    end else begin : g_next
      assign valid_prev = g_stage[s-1].valid_q;
      assign in_prev    = g_stage[s-1].in_q;
      assign tag_prev   = g_stage[s-1].tag_q;
      assign root_prev  = g_stage[s-1].root_q;
      assign sq_prev    = g_stage[s-1].sq_q;
    end

    // Trial: (root + 2^B)^2 = root^2 + root*2^(B+1) + 2^(2B); keep the bit if it fits.
    always_comb begin
      cand_sq = sq_prev + (SQ_WIDTH'(root_prev) << (B + 1)) + (SQ_WIDTH'(1) << (2 * B));
      root_d  = root_prev;
      sq_d    = sq_prev;
      if (cand_sq <= {1'b0, in_prev}) begin
        root_d = root_prev | (ROOT_WIDTH'(1) << B);
        sq_d   = cand_sq;
      end
    end

    // Stage register: loads from the predecessor whenever the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        in_q    <= '0;
        tag_q   <= '0;
        root_q  <= '0;
        sq_q    <= '0;
      end else if (en) begin
        valid_q <= valid_prev;
        in_q    <= in_prev;
        tag_q   <= tag_prev;
        root_q  <= root_d;
        sq_q    <= sq_d;
      end
    end
  end

  assign out_valid_o = g_stage[ROOT_WIDTH-1].valid_q;
  assign root_o      = g_stage[ROOT_WIDTH-1].root_q;
  assign tag_o       = g_stage[ROOT_WIDTH-1].tag_q;

  // Remainder never exceeds 2*root, so the low bits of the difference are exact.
  assign rem_o = g_stage[ROOT_WIDTH-1].in_q[REM_WIDTH-1:0]
               - g_stage[ROOT_WIDTH-1].sq_q[REM_WIDTH-1:0];

  // Pipe advances unless a held result is blocked by the consumer.
  assign en         = !out_valid_o || out_ready_i;
  assign in_ready_o = en;

endmodule
